dot_product_sequencer: RTL and testbench
========================================

Name: dot_product_sequencer

Overview:
- Upstream controller for the mult_add stage.
- Computes acc = init_acc + sum of a[i]*b[i] for i = 0..vec_len-1 by issuing one multiply-add per element pair.
- Operands come from a dual-output synchronous coefficient RAM. Each mult_add result is fed back as the addend of the next operation.
- Sits between the polynomial/vector storage and mult_add. It is the only driver of mult_add's start and operand inputs.

Parameters:
- DATA_WIDTH, 32, width of coefficients, accumulator and mult_add operands.
- ADDR_WIDTH, 8, coefficient RAM address width; maximum vector length is 2^ADDR_WIDTH-1.
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for one mult_add result before aborting.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new dot product; sampled only in IDLE.
- vec_len  in  ADDR_WIDTH  number of element pairs; sampled with start.
- init_acc  in  DATA_WIDTH  initial accumulator value; sampled with start.
- rd_en  out  1  RAM read enable.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- rd_data_a  in  DATA_WIDTH  RAM word a[rd_addr]; valid the cycle after rd_en.
- rd_data_b  in  DATA_WIDTH  RAM word b[rd_addr]; valid the cycle after rd_en.
- ma_inp_a  out  DATA_WIDTH  to mult_add inp_values[0] (multiplicand).
- ma_inp_b  out  DATA_WIDTH  to mult_add inp_values[1] (multiplier).
- ma_inp_c  out  DATA_WIDTH  to mult_add inp_values[2] (addend = running acc).
- ma_start  out  1  to mult_add start_mult_add; single-cycle pulse.
- ma_out_value  in  DATA_WIDTH  from mult_add out_value.
- ma_data_ready  in  1  from mult_add data_ready; single-cycle pulse.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  single-cycle completion pulse.
- result  out  DATA_WIDTH  final accumulator; held until the next done.
- timeout_err  out  1  sticky abort flag; cleared on the next accepted start.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs are 0: rd_en, rd_addr, ma_inp_a/b/c, ma_start, busy, done, result, timeout_err.
  - Internal idx, acc and wait counter are 0.
  - Reset asserted mid-operation abandons the operation. No done pulse is produced.
  - A mult_add result arriving after reset is ignored.
- States: IDLE, READ, LATCH, ISSUE, WAIT, FINISH.
- IDLE:
  - On start=1: acc<=init_acc, idx<=0, len<=vec_len, timeout_err<=0, busy<=1.
  - If vec_len==0, go to FINISH. Otherwise go to READ.
  - start while not in IDLE is ignored; it is neither queued nor an error.
- READ: rd_en=1, rd_addr=idx for exactly this cycle; go to LATCH.
- LATCH: rd_en=0; ma_inp_a<=rd_data_a, ma_inp_b<=rd_data_b, ma_inp_c<=acc; go to ISSUE.
- ISSUE: ma_start=1 for this one cycle; wait counter<=0; go to WAIT.
  - Operands stay stable from LATCH until the WAIT exit.
- WAIT: ma_start=0; counter increments each cycle.
  - On ma_data_ready=1: acc<=ma_out_value.
    - If idx==len-1, go to FINISH.
    - Otherwise idx<=idx+1 and go to READ.
  - If the counter reaches TIMEOUT_CYCLES with no ready: timeout_err<=1, go to FINISH. acc keeps the partial sum.
  - If ready and the timeout fall on the same cycle, ready wins.
- FINISH: result<=acc, done=1 for one cycle, busy<=0; go to IDLE.
- Latency:
  - Per element: 3 cycles (READ, LATCH, ISSUE) plus mult_add latency L, measured from ma_start to ma_data_ready.
  - Total: start accepted at cycle 0, done asserted at cycle 1 + N*(3+L) + 1.
  - vec_len==0: done at cycle 2 with result=init_acc.
- ma_data_ready outside WAIT is ignored.
- Arithmetic: none is performed locally. Wrap modulo 2^DATA_WIDTH is inherited from mult_add and passed through unchanged.
- idx never exceeds len-1. rd_addr never wraps.
- vec_len = 2^ADDR_WIDTH-1 is legal.

Test Plan:
- Use a behavioural mult_add with L=4. Let a=[1,2,3], b=[4,5,6], init_acc=10, vec_len=3. Required: result=42, done one pulse at cycle 23, exactly 3 ma_start pulses, rd_addr sequence 0,1,2.
- vec_len=0, init_acc=0xDEADBEEF -> done at cycle 2, result=0xDEADBEEF, no rd_en, no ma_start.
- Wrap: a[0]=b[0]=0xFFFFFFFF, init_acc=1, vec_len=1 -> result=2 (mod 2^32). Check ma_inp_c=1 at ISSUE.
- Model never asserts ready, TIMEOUT_CYCLES=16 -> timeout_err=1 and done after the 16 wait cycles. result equals the partial acc; the next start clears timeout_err.
- Assert start again in WAIT, and pulse a spurious ma_data_ready during READ -> both ignored; result unchanged versus the clean run.
- Drop reset_n during the second WAIT of a 3-element run -> outputs 0 immediately. The late ma_data_ready is ignored, no done pulse, and a fresh run afterwards gives the correct result.

Source files
------------

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//   Upstream controller for the mult_add stage. Computes
//   result = init_acc + sum(a[i]*b[i]), i = 0..vec_len-1, by reading one
//   operand pair per element from a dual-output synchronous RAM and issuing
//   one multiply-add per pair. Each mult_add result becomes the addend of
//   the next operation. No arithmetic is performed here.
//
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   start, vec_len,         request a dot product; vec_len and init_acc are
//   init_acc                sampled together with start while idle
//   rd_en, rd_addr          RAM read request (data valid the following cycle)
//   rd_data_a, rd_data_b    RAM words a[rd_addr], b[rd_addr]
//   ma_inp_a/b/c, ma_start  operands and start pulse to mult_add
//   ma_out_value,           mult_add result and its single-cycle ready pulse
//   ma_data_ready
//   busy, done, result      status, completion pulse, held final accumulator
//   timeout_err             sticky abort flag, cleared by the next start
module dot_product_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] vec_len,
    input  logic [DATA_WIDTH-1:0] init_acc,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [DATA_WIDTH-1:0] ma_inp_a,
    output logic [DATA_WIDTH-1:0] ma_inp_b,
    output logic [DATA_WIDTH-1:0] ma_inp_c,
    output logic                  ma_start,
    input  logic [DATA_WIDTH-1:0] ma_out_value,
    input  logic                  ma_data_ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  timeout_err
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] len;
    logic [DATA_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]  wait_cnt;
    logic                  last_elem;
    logic                  wait_expired;

    assign last_elem    = (idx == len - ADDR_WIDTH'(1));
    // Counter is cleared in ISSUE, so reaching TIMEOUT_CYCLES-1 here marks
    // the final permitted WAIT cycle.
    assign wait_expired = (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign rd_addr      = idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        ma_start   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (vec_len == '0) ? FINISH : READ;
                end
            end
            READ: begin
                rd_en      = 1'b1;
                state_next = LATCH;
            end
            LATCH: begin
                state_next = ISSUE;
            end
            ISSUE: begin
                ma_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A ready on the expiry cycle still counts as success.
                if (ma_data_ready) begin
                    state_next = last_elem ? FINISH : READ;
                end else if (wait_expired) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            len         <= '0;
            acc         <= '0;
            wait_cnt    <= '0;
            ma_inp_a    <= '0;
            ma_inp_b    <= '0;
            ma_inp_c    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc         <= init_acc;
                        idx         <= '0;
                        len         <= vec_len;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                READ: begin
                end
                LATCH: begin
                    ma_inp_a <= rd_data_a;
                    ma_inp_b <= rd_data_b;
                    ma_inp_c <= acc;
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (ma_data_ready) begin
                        acc <= ma_out_value;
                        if (!last_elem) begin
                            idx <= idx + ADDR_WIDTH'(1);
                        end
                    end else if (wait_expired) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                    end
                end
                FINISH: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer
//   Directed bench for dot_product_sequencer with a synchronous coefficient
//   RAM and a behavioural mult_add of latency 4. Cycle 0 is the cycle in
//   which start is sampled; observations are taken on falling edges.
module tb_dot_product_sequencer;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int TO  = 16;
    localparam int LAT = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] vec_len = '0;
    logic [DW-1:0] init_acc = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_a = '0;
    logic [DW-1:0] rd_data_b = '0;
    logic [DW-1:0] ma_inp_a, ma_inp_b, ma_inp_c;
    logic          ma_start;
    logic [DW-1:0] ma_out_value;
    logic          ma_data_ready;
    logic          busy, done, timeout_err;
    logic [DW-1:0] result;

    int vectors = 0;
    int miscompares = 0;

    dot_product_sequencer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .vec_len(vec_len),
        .init_acc(init_acc),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .ma_inp_a(ma_inp_a),
        .ma_inp_b(ma_inp_b),
        .ma_inp_c(ma_inp_c),
        .ma_start(ma_start),
        .ma_out_value(ma_out_value),
        .ma_data_ready(ma_data_ready),
        .busy(busy),
        .done(done),
        .result(result),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    // Coefficient RAM: data valid the cycle after rd_en.
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    always @(posedge clock) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr];
            rd_data_b <= mem_b[rd_addr];
        end
    end

    // Behavioural mult_add; answers only while n_issued < resp_limit.
    logic [LAT-1:0] pipe = '0;
    logic [DW-1:0]  mval = '0;
    int             n_issued = 0;
    int             resp_limit = 0;
    logic           spur = 1'b0;
    logic [DW-1:0]  spur_val = 32'd999;
    always @(posedge clock) begin
        pipe <= {pipe[LAT-2:0], ma_start && (n_issued < resp_limit)};
        if (ma_start) begin
            mval     <= ma_inp_a * ma_inp_b + ma_inp_c;
            n_issued <= n_issued + 1;
        end
    end
    assign ma_data_ready = pipe[LAT-1] | spur;
    assign ma_out_value  = spur ? spur_val : mval;

    // Observations of the most recent run.
    int            obs_done_cyc, obs_n_done, obs_n_ms, obs_n_rd;
    logic [DW-1:0] obs_res, obs_first_c;
    logic [AW-1:0] obs_addr [8];
    logic          obs_busy1, obs_te1, obs_busy_done, obs_rst_zero;

    task automatic run_op(input logic [AW-1:0] len, input logic [DW-1:0] ia,
                          input int restart_cyc, input int spur_cyc, input int rst_cyc);
        obs_done_cyc = -1; obs_n_done = 0; obs_n_ms = 0; obs_n_rd = 0;
        obs_res = '0; obs_first_c = '0; obs_busy1 = 1'b0; obs_te1 = 1'b1;
        obs_busy_done = 1'b1; obs_rst_zero = 1'b0;
        for (int i = 0; i < 8; i++) obs_addr[i] = '1;
        @(negedge clock);
        vec_len = len; init_acc = ia; start = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            start   = (c == restart_cyc);
            vec_len = (c == restart_cyc) ? AW'(7) : len;
            spur    = (c == spur_cyc);
            if (c == rst_cyc) begin
                reset_n = 1'b0;
                #1;
                obs_rst_zero = ({rd_en, rd_addr, ma_inp_a, ma_inp_b, ma_inp_c, ma_start,
                                 busy, done, result, timeout_err} == '0);
            end
            if (rst_cyc > 0 && c == rst_cyc + 1) reset_n = 1'b1;
            if (c == 1) begin
                obs_busy1 = busy;
                obs_te1   = timeout_err;
            end
            if (done) begin
                obs_n_done++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc  = c;
                    obs_res       = result;
                    obs_busy_done = busy;
                end
            end
            if (ma_start) begin
                if (obs_n_ms == 0) obs_first_c = ma_inp_c;
                obs_n_ms++;
            end
            if (rd_en) begin
                if (obs_n_rd < 8) obs_addr[obs_n_rd] = rd_addr;
                obs_n_rd++;
            end
            if (obs_done_cyc >= 0 && c >= obs_done_cyc + 2) break;
            if (rst_cyc > 0 && c >= rst_cyc + 20) break;
        end
        start = 1'b0;
        spur  = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3;
        mem_b[0] = 4; mem_b[1] = 5; mem_b[2] = 6;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({rd_en, ma_start, busy, done, timeout_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 00000", {rd_en, ma_start, busy, done, timeout_err});
        end
        vectors++;
        if ({ma_inp_a, ma_inp_b, ma_inp_c, result, rd_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got a=%h b=%h c=%h res=%h addr=%h expected all 0",
                     ma_inp_a, ma_inp_b, ma_inp_c, result, rd_addr);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        load_basic();
        resp_limit = n_issued + 100;
        run_op(3, 10, -1, -1, -1);
        vectors++;
        if (obs_res !== 32'd42) begin
            miscompares++; $display("FAIL basic_result: got %0d expected 42", obs_res);
        end
        vectors++;
        if (obs_done_cyc !== 23) begin
            miscompares++; $display("FAIL basic_done_cycle: got %0d expected 23", obs_done_cyc);
        end
        vectors++;
        if (obs_n_done !== 1) begin
            miscompares++; $display("FAIL basic_done_pulses: got %0d expected 1", obs_n_done);
        end
        vectors++;
        if (obs_n_ms !== 3) begin
            miscompares++; $display("FAIL basic_ma_start_count: got %0d expected 3", obs_n_ms);
        end
        vectors++;
        if (obs_n_rd !== 3 || obs_addr[0] !== 8'd0 || obs_addr[1] !== 8'd1 || obs_addr[2] !== 8'd2) begin
            miscompares++;
            $display("FAIL basic_rd_addr: got n=%0d %0d,%0d,%0d expected n=3 0,1,2",
                     obs_n_rd, obs_addr[0], obs_addr[1], obs_addr[2]);
        end
        vectors++;
        if (obs_busy1 !== 1'b1 || obs_busy_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy: got cyc1=%b at_done=%b expected 1/0", obs_busy1, obs_busy_done);
        end
    endtask

    task automatic test_empty();
        run_op(0, 32'hDEADBEEF, -1, -1, -1);
        vectors++;
        if (obs_done_cyc !== 2 || obs_res !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL empty_done: got cyc=%0d res=%h expected cyc=2 res=deadbeef", obs_done_cyc, obs_res);
        end
        vectors++;
        if (obs_n_rd !== 0 || obs_n_ms !== 0) begin
            miscompares++;
            $display("FAIL empty_no_access: got rd=%0d ms=%0d expected 0/0", obs_n_rd, obs_n_ms);
        end
    endtask

    task automatic test_wrap();
        mem_a[0] = 32'hFFFF_FFFF;
        mem_b[0] = 32'hFFFF_FFFF;
        resp_limit = n_issued + 100;
        run_op(1, 1, -1, -1, -1);
        vectors++;
        if (obs_res !== 32'd2 || obs_done_cyc !== 9) begin
            miscompares++;
            $display("FAIL wrap_result: got res=%0d cyc=%0d expected res=2 cyc=9", obs_res, obs_done_cyc);
        end
        vectors++;
        if (obs_first_c !== 32'd1) begin
            miscompares++; $display("FAIL wrap_addend: got %0d expected 1", obs_first_c);
        end
    endtask

    task automatic test_timeout();
        load_basic();
        resp_limit = n_issued + 1;
        run_op(2, 10, -1, -1, -1);
        vectors++;
        if (obs_done_cyc !== 28 || obs_res !== 32'd14) begin
            miscompares++;
            $display("FAIL timeout_done: got cyc=%0d res=%0d expected cyc=28 res=14", obs_done_cyc, obs_res);
        end
        vectors++;
        if (timeout_err !== 1'b1) begin
            miscompares++; $display("FAIL timeout_flag: got %b expected 1", timeout_err);
        end
        resp_limit = n_issued + 100;
        run_op(1, 10, -1, -1, -1);
        vectors++;
        if (obs_te1 !== 1'b0 || timeout_err !== 1'b0 || obs_res !== 32'd14) begin
            miscompares++;
            $display("FAIL timeout_clear: got te1=%b te=%b res=%0d expected 0/0/14", obs_te1, timeout_err, obs_res);
        end
    endtask

    task automatic test_ignored_inputs();
        load_basic();
        resp_limit = n_issued + 100;
        run_op(3, 10, 5, 8, -1);
        vectors++;
        if (obs_res !== 32'd42 || obs_done_cyc !== 23) begin
            miscompares++;
            $display("FAIL ignore_result: got res=%0d cyc=%0d expected 42/23", obs_res, obs_done_cyc);
        end
        vectors++;
        if (obs_n_ms !== 3 || obs_n_done !== 1) begin
            miscompares++;
            $display("FAIL ignore_counts: got ms=%0d done=%0d expected 3/1", obs_n_ms, obs_n_done);
        end
    endtask

    task automatic test_reset_mid();
        load_basic();
        resp_limit = n_issued + 100;
        run_op(3, 10, -1, -1, 12);
        vectors++;
        if (obs_rst_zero !== 1'b1) begin
            miscompares++; $display("FAIL midreset_outputs: got zero=%b expected 1", obs_rst_zero);
        end
        vectors++;
        if (obs_n_done !== 0 || busy !== 1'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL midreset_late_ready: got done=%0d busy=%b res=%0d expected 0/0/0",
                     obs_n_done, busy, result);
        end
        run_op(3, 10, -1, -1, -1);
        vectors++;
        if (obs_res !== 32'd42 || obs_done_cyc !== 23) begin
            miscompares++;
            $display("FAIL midreset_rerun: got res=%0d cyc=%0d expected 42/23", obs_res, obs_done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_wrap();
        test_timeout();
        test_ignored_inputs();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
